// File: rtl/pg_table_update_ctrl.sv
// pg_table_update_ctrl: buffers host-staged table entries and bursts them into port_group
// tables inside a traffic hold window once the port group has gone quiet.
module pg_table_update_ctrl #(
  parameter int RULE_AWIDTH   = 12,
  parameter int RULE_PG_WIDTH = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int DRAIN_CYCLES  = 20,
  parameter int MAX_BATCH     = 8,
  parameter int GAP_CYCLES    = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_valid,
  input  logic [1:0]                        cfg_addr,
  input  logic [31:0]                       cfg_data,
  output logic                              cfg_ready,
  input  logic                              pg_idle,
  output logic                              hold,
  output logic [2*RULE_PG_WIDTH-1:0]        wr_data,
  output logic [RULE_AWIDTH-1:0]            wr_addr,
  output logic                              wr_en,
  output logic [$clog2(FIFO_DEPTH):0]       pending,
  output logic [31:0]                       entries_written,
  output logic [31:0]                       batches
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 2 * RULE_PG_WIDTH;
  localparam int EW = DW + RULE_AWIDTH;
  typedef enum logic [2:0] {IDLE, HOLD, DRAIN, WRITE, RELEASE} state_t;
  state_t                   state_q;
  logic [EW-1:0]            mem_q [FIFO_DEPTH];
  logic [PW-1:0]            wp_q, rp_q;
  logic [CW-1:0]            count_q, count_d;
  logic [RULE_PG_WIDTH-1:0] lo_q, hi_q;
  logic [31:0]              gap_q, drain_q, batch_q, entries_q, batches_q;
  logic                     first_q, hold_q, wr_en_q, cfg_ready_q;
  logic [DW-1:0]            wr_data_q;
  logic [RULE_AWIDTH-1:0]   wr_addr_q;
  logic                     acc, push, pop;
  assign cfg_ready       = cfg_ready_q;
  assign hold            = hold_q;
  assign wr_en           = wr_en_q;
  assign wr_data         = wr_data_q;
  assign wr_addr         = wr_addr_q;
  assign pending         = count_q;
  assign entries_written = entries_q;
  assign batches         = batches_q;
  // Pops happen on the last DRAIN edge and on each WRITE edge, so wr_en lines up with WRITE cycles.
  always_comb begin
    acc     = cfg_valid && cfg_ready_q;
    push    = acc && cfg_addr == 2'd2;
    pop     = count_q != '0 && ((state_q == DRAIN && drain_q == '0) ||
                                (state_q == WRITE && batch_q < 32'(MAX_BATCH)));
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {RULE_AWIDTH'(cfg_data), hi_q, lo_q};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      gap_q       <= '0;
      drain_q     <= '0;
      batch_q     <= '0;
      entries_q   <= '0;
      batches_q   <= '0;
      first_q     <= 1'b0;
      hold_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
    end else begin
      cfg_ready_q <= count_d != CW'(FIFO_DEPTH);
      count_q     <= count_d;
      wr_en_q     <= pop;
      if (acc && cfg_addr == 2'd0) lo_q <= RULE_PG_WIDTH'(cfg_data);
      if (acc && cfg_addr == 2'd1) hi_q <= RULE_PG_WIDTH'(cfg_data);
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) begin
        rp_q                   <= rp_q + 1'b1;
        {wr_addr_q, wr_data_q} <= mem_q[rp_q];
        entries_q              <= entries_q + 1;
        batch_q                <= batch_q + 1;
      end
      case (state_q)
        IDLE: begin
          if (gap_q != '0) gap_q <= gap_q - 1;
          else if (count_q != '0) begin
            state_q <= HOLD;
            hold_q  <= 1'b1;
            first_q <= 1'b1;
            batch_q <= '0;
          end
        end
        HOLD: begin
          // A packet may slip in while hold is rising, so pg_idle is only trusted from the second cycle.
          first_q <= 1'b0;
          if (!first_q && pg_idle) begin
            state_q <= DRAIN;
            drain_q <= 32'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_q == '0) state_q <= WRITE;
          else drain_q <= drain_q - 1;
        end
        WRITE: begin
          if (!pop) begin
            state_q <= RELEASE;
            hold_q  <= 1'b0;
          end
        end
        RELEASE: begin
          batches_q <= batches_q + 1;
          gap_q     <= 32'(GAP_CYCLES);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pg_table_update_ctrl.sv
// tb_pg_table_update_ctrl: randomized scenario bench with a queue-based entry scoreboard and
// hold-window bookkeeping derived from the controller's externally visible behaviour.
module tb_pg_table_update_ctrl;
  localparam int DRAIN = 20;
  localparam int MAXB  = 8;
  localparam int GAP   = 32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ready;
  logic        pg_idle = 1'b1;
  logic        hold;
  logic [63:0] wr_data;
  logic [11:0] wr_addr;
  logic        wr_en;
  logic [4:0]  pending;
  logic [31:0] entries_written, batches;
  int n_cmp = 0, n_bad = 0;
  logic [75:0] exp_q[$];
  logic [75:0] mon_e;
  logic [31:0] m_lo = '0, m_hi = '0;
  int accepted = 0, writes = 0, windows = 0;
  int cur_len = 0, cur_wr = 0, cur_gap = 0;
  bit hold_prev = 0, seen_window = 0;
  int win_len[$], win_wr[$], win_gap[$];
  logic [63:0] last_data = '0;
  logic [11:0] last_addr = '0;

  pg_table_update_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .pg_idle(pg_idle), .hold(hold), .wr_data(wr_data), .wr_addr(wr_addr),
    .wr_en(wr_en), .pending(pending), .entries_written(entries_written), .batches(batches)
  );

  always #5 clk = ~clk;

  // Scoreboard and window bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 0; cur_len = 0; cur_wr = 0; cur_gap = 0; seen_window = 0; writes = 0; windows = 0;
    end else begin
      if (wr_en) begin
        writes++;
        cur_wr++;
        last_data = wr_data;
        last_addr = wr_addr;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL wr_unexpected: got addr %h data %h, required no write (model queue empty)", wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== mon_e) begin
            n_bad++;
            $display("FAIL wr_entry: got %h, required %h", {wr_addr, wr_data}, mon_e);
          end
        end
      end
      n_cmp++;
      if (int'(pending) !== accepted - writes) begin
        n_bad++;
        $display("FAIL pending: got %0d, required %0d", pending, accepted - writes);
      end
      if (hold) begin
        if (!hold_prev) begin
          if (seen_window) win_gap.push_back(cur_gap);
          cur_len = 0;
        end
        cur_len++;
      end else begin
        if (hold_prev) begin
          win_len.push_back(cur_len);
          win_wr.push_back(cur_wr);
          windows++;
          seen_window = 1;
          cur_gap = 0;
          cur_wr = 0;
        end
        cur_gap++;
      end
      hold_prev = hold;
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    int c = 0;
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    while (!cfg_ready && c < 200) begin @(negedge clk); c++; end
    if (c >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL cfg_timeout: got cfg_ready=0 for 200 cycles, required acceptance");
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (a == 2'd0) m_lo = d;
    else if (a == 2'd1) m_hi = d;
    else if (a == 2'd2) begin exp_q.push_back({d[11:0], m_hi, m_lo}); accepted++; end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pg_idle = 1'b1;
    idle_cycles(3);
    n_cmp += 8;
    if (hold !== 1'b0) begin n_bad++; $display("FAIL rst_hold: got %b, required 0", hold); end
    if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b, required 0", wr_en); end
    if (pending !== 5'd0) begin n_bad++; $display("FAIL rst_pending: got %0d, required 0", pending); end
    if (wr_addr !== 12'd0) begin n_bad++; $display("FAIL rst_wr_addr: got %h, required 0", wr_addr); end
    if (wr_data !== 64'd0) begin n_bad++; $display("FAIL rst_wr_data: got %h, required 0", wr_data); end
    if (entries_written !== 32'd0) begin n_bad++; $display("FAIL rst_entries: got %0d, required 0", entries_written); end
    if (batches !== 32'd0) begin n_bad++; $display("FAIL rst_batches: got %0d, required 0", batches); end
    if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_ready: got %b, required 0", cfg_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_rise: got %b, required 1", cfg_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    int c = 0;
    int k;
    cfg_write(2'd0, 32'hDEADBEEF);
    cfg_write(2'd1, 32'h12345678);
    cfg_write(2'd2, 32'h0000005A);
    n_cmp += 2;
    if (pending !== 5'd1) begin n_bad++; $display("FAIL single_pending: got %0d, required 1", pending); end
    if (hold !== 1'b0) begin n_bad++; $display("FAIL single_hold_early: got %b, required 0", hold); end
    @(negedge clk);
    n_cmp++;
    if (hold !== 1'b1) begin n_bad++; $display("FAIL single_hold_rise: got %b, required 1", hold); end
    while (windows < 1 && c < 200) begin @(negedge clk); c++; end
    idle_cycles(2);
    n_cmp++;
    if (windows < 1) begin n_bad++; $display("FAIL single_timeout: got %0d windows, required 1", windows); end
    else begin
      k = windows - 1;
      n_cmp += 6;
      if (win_len[k] !== DRAIN + 3) begin n_bad++; $display("FAIL single_hold_len: got %0d, required %0d", win_len[k], DRAIN + 3); end
      if (win_wr[k] !== 1) begin n_bad++; $display("FAIL single_writes: got %0d, required 1", win_wr[k]); end
      if (last_data !== 64'h12345678DEADBEEF) begin n_bad++; $display("FAIL single_data: got %h, required 12345678deadbeef", last_data); end
      if (last_addr !== 12'h05A) begin n_bad++; $display("FAIL single_addr: got %h, required 05a", last_addr); end
      if (entries_written !== 32'd1) begin n_bad++; $display("FAIL single_entries: got %0d, required 1", entries_written); end
      if (batches !== 32'd1) begin n_bad++; $display("FAIL single_batches: got %0d, required 1", batches); end
    end
    idle_cycles(40);
  endtask

  task automatic test_batching();
    int base = windows;
    int c = 0;
    cfg_write(2'd0, $urandom);
    cfg_write(2'd1, $urandom);
    for (int i = 0; i < 12; i++) cfg_write(2'd2, $urandom);
    while (windows < base + 2 && c < 400) begin @(negedge clk); c++; end
    idle_cycles(2);
    n_cmp++;
    if (windows < base + 2) begin n_bad++; $display("FAIL batch_timeout: got %0d windows, required %0d", windows - base, 2); end
    else begin
      n_cmp += 5;
      if (win_wr[base] !== MAXB) begin n_bad++; $display("FAIL batch_w1: got %0d, required %0d", win_wr[base], MAXB); end
      if (win_wr[base + 1] !== 4) begin n_bad++; $display("FAIL batch_w2: got %0d, required 4", win_wr[base + 1]); end
      if (win_gap[base] < GAP) begin n_bad++; $display("FAIL batch_gap: got %0d, required >= %0d", win_gap[base], GAP); end
      if (batches !== 32'(base + 2)) begin n_bad++; $display("FAIL batch_count: got %0d, required %0d", batches, base + 2); end
      if (entries_written !== 32'(writes)) begin n_bad++; $display("FAIL batch_entries: got %0d, required %0d", entries_written, writes); end
    end
    idle_cycles(40);
  endtask

  task automatic test_busy();
    int c = 0;
    int bad = 0;
    pg_idle = 1'b0;
    cfg_write(2'd2, $urandom);
    while (!hold && c < 50) begin @(negedge clk); c++; end
    n_cmp++;
    if (!hold) begin n_bad++; $display("FAIL busy_hold_rise: got hold=0, required 1"); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_en || !hold) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL busy_blocked: got %0d bad cycles, required 0", bad); end
    pg_idle = 1'b1;
    c = 0;
    bad = 0;
    while (!wr_en && c < 100) begin @(negedge clk); c++; if (!hold) bad++; end
    n_cmp += 2;
    if (c !== DRAIN + 1) begin n_bad++; $display("FAIL busy_latency: got %0d, required %0d", c, DRAIN + 1); end
    if (bad != 0) begin n_bad++; $display("FAIL busy_hold_drop: got %0d low cycles, required 0", bad); end
    idle_cycles(80);
  endtask

  task automatic test_full();
    int base = windows;
    int bad = 0;
    int c = 0;
    pg_idle = 1'b0;
    cfg_write(2'd0, $urandom);
    cfg_write(2'd1, $urandom);
    for (int i = 0; i < 16; i++) cfg_write(2'd2, $urandom);
    n_cmp += 2;
    if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b, required 0", cfg_ready); end
    if (pending !== 5'd16) begin n_bad++; $display("FAIL full_pending: got %0d, required 16", pending); end
    cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cfg_ready !== 1'b0 || pending !== 5'd16) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL full_blocked: got %0d accepting cycles, required 0", bad); end
    pg_idle = 1'b1;
    cfg_write(2'd2, cfg_data);
    n_cmp++;
    if (writes < 1) begin n_bad++; $display("FAIL full_accept_early: got %0d writes before accept, required >= 1", writes); end
    while ((exp_q.size() != 0 || hold) && c < 800) begin @(negedge clk); c++; end
    idle_cycles(2);
    n_cmp++;
    if (windows - base !== 3) begin n_bad++; $display("FAIL full_windows: got %0d, required 3", windows - base); end
    else begin
      n_cmp++;
      if (win_wr[base] !== MAXB || win_wr[base + 1] !== MAXB || win_wr[base + 2] !== 1) begin
        n_bad++;
        $display("FAIL full_split: got %0d/%0d/%0d, required 8/8/1", win_wr[base], win_wr[base + 1], win_wr[base + 2]);
      end
    end
    idle_cycles(40);
  endtask

  task automatic test_random();
    int c = 0;
    for (int i = 0; i < 600; i++) begin
      pg_idle = $urandom_range(0, 3) != 0;
      if (cfg_ready && $urandom_range(0, 2) == 0) cfg_write(2'($urandom_range(0, 3)), $urandom);
      else @(negedge clk);
    end
    pg_idle = 1'b1;
    while ((exp_q.size() != 0 || hold) && c < 3000) begin @(negedge clk); c++; end
    idle_cycles(2);
    n_cmp += 3;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_drain: got %0d entries left, required 0", exp_q.size()); end
    if (entries_written !== 32'(writes)) begin n_bad++; $display("FAIL rand_entries: got %0d, required %0d", entries_written, writes); end
    if (batches !== 32'(windows)) begin n_bad++; $display("FAIL rand_batches: got %0d, required %0d", batches, windows); end
    for (int i = 0; i < win_wr.size(); i++) begin
      n_cmp++;
      if (win_wr[i] < 1 || win_wr[i] > MAXB || win_len[i] < DRAIN + 2 + win_wr[i]) begin
        n_bad++;
        $display("FAIL rand_window: window %0d got %0d writes in %0d cycles, required 1..%0d writes in >= %0d", i, win_wr[i], win_len[i], MAXB, DRAIN + 2 + win_wr[i]);
      end
    end
    for (int i = 0; i < win_gap.size(); i++) begin
      n_cmp++;
      if (win_gap[i] < GAP) begin n_bad++; $display("FAIL rand_gap: gap %0d got %0d, required >= %0d", i, win_gap[i], GAP); end
    end
    idle_cycles(40);
  endtask

  task automatic test_reset_mid_write();
    int c = 0;
    pg_idle = 1'b1;
    cfg_write(2'd0, $urandom);
    cfg_write(2'd1, $urandom);
    for (int i = 0; i < 4; i++) cfg_write(2'd2, $urandom);
    while (!wr_en && c < 100) begin @(negedge clk); c++; end
    n_cmp++;
    if (!wr_en) begin n_bad++; $display("FAIL midrst_no_write: got wr_en=0, required a write"); end
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    accepted = 0;
    m_lo = '0; m_hi = '0;
    #1;
    n_cmp += 4;
    if (hold !== 1'b0) begin n_bad++; $display("FAIL midrst_hold: got %b, required 0", hold); end
    if (wr_en !== 1'b0) begin n_bad++; $display("FAIL midrst_wr_en: got %b, required 0", wr_en); end
    if (pending !== 5'd0) begin n_bad++; $display("FAIL midrst_pending: got %0d, required 0", pending); end
    if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b, required 0", cfg_ready); end
    idle_cycles(2);
    win_len.delete(); win_wr.delete(); win_gap.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready_rise: got %b, required 1", cfg_ready); end
    idle_cycles(60);
    n_cmp += 3;
    if (entries_written !== 32'd0) begin n_bad++; $display("FAIL midrst_entries: got %0d, required 0", entries_written); end
    if (batches !== 32'd0) begin n_bad++; $display("FAIL midrst_batches: got %0d, required 0", batches); end
    if (hold !== 1'b0) begin n_bad++; $display("FAIL midrst_rehold: got %b, required 0", hold); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_batching();
    test_busy();
    test_full();
    test_random();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
